// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands/control, decodes alu_ctrl, resolves forwarding; 1-cycle latency.
// Backpressure: stall holds the EX register; a load-use hazard inserts a bubble and deasserts in_ready.
module id_ex_stage #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            stall,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            id_alu_src,
   input  logic [1:0]      id_alu_op,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7_5,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_branch,
   input  logic [4:0]      exmem_rd,
   input  logic [4:0]      memwb_rd,
   input  logic            exmem_reg_write,
   input  logic            memwb_reg_write,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rd,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic            ex_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            alu_src;
      logic [3:0]      alu_ctrl;
   } ex_dat_t;

   ex_dat_t         ex_dat;
   logic [3:0]      ctrl_d;
   logic            illegal_d;
   logic            load_use;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   always_comb begin
      ctrl_d    = 4'b1111;
      illegal_d = 1'b0;
      case (id_alu_op)
         2'b00: ctrl_d = 4'b0010;
         2'b01: ctrl_d = 4'b0110;
         2'b10: begin
            case (id_funct3)
               3'b000:  ctrl_d = (id_funct7_5 & ~id_alu_src) ? 4'b0110 : 4'b0010;
               3'b111:  ctrl_d = 4'b0000;
               3'b110:  ctrl_d = 4'b0001;
               default: illegal_d = 1'b1;
            endcase
         end
         default: illegal_d = 1'b1;
      endcase
   end

   // The instruction in EX is a load whose result an ID operand needs next cycle.
   assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & in_valid &
                     ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));
   assign in_ready = ~stall & ~load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_dat       <= '0;
         ex_dat.pc    <= RESET_PC;
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_branch    <= 1'b0;
         ex_illegal   <= 1'b0;
      end else if (flush || (!stall && (load_use || !in_valid))) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_branch    <= 1'b0;
         ex_illegal   <= 1'b0;
      end else if (!stall) begin
         ex_dat.pc       <= id_pc;
         ex_dat.imm      <= id_imm;
         ex_dat.rs1_data <= id_rs1_data;
         ex_dat.rs2_data <= id_rs2_data;
         ex_dat.rs1      <= id_rs1;
         ex_dat.rs2      <= id_rs2;
         ex_dat.rd       <= id_rd;
         ex_dat.alu_src  <= id_alu_src;
         ex_dat.alu_ctrl <= ctrl_d;
         ex_valid        <= 1'b1;
         ex_reg_write    <= id_reg_write & ~illegal_d;
         ex_mem_read     <= id_mem_read;
         ex_mem_write    <= id_mem_write & ~illegal_d;
         ex_branch       <= id_branch;
         ex_illegal      <= illegal_d;
      end
   end

   // EX/MEM is the younger producer, so it wins when both stages match.
   always_comb begin
      fwd_rs1 = ex_dat.rs1_data;
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_dat.rs1)
         fwd_rs1 = exmem_result;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_dat.rs1)
         fwd_rs1 = memwb_result;

      fwd_rs2 = ex_dat.rs2_data;
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_dat.rs2)
         fwd_rs2 = exmem_result;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_dat.rs2)
         fwd_rs2 = memwb_result;
   end

   assign alu_a         = fwd_rs1;
   assign alu_b         = ex_dat.alu_src ? ex_dat.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign alu_ctrl      = ex_dat.alu_ctrl;
   assign ex_pc         = ex_dat.pc;
   assign ex_rd         = ex_dat.rd;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32I core; sits directly upstream of the ALU and drives its operand A, operand B and 4-bit control inputs.
- Captures decoded operands and control, and generates the ALU control code from alu_op/funct3/funct7[5].
- Resolves EX/MEM and MEM/WB data forwarding and detects load-use hazards, inserting a one-cycle bubble when one occurs.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, reset value of ex_pc

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  branch/jump redirect; kill instruction entering EX
stall  in  1  downstream stall; hold EX register
in_valid  in  1  ID holds a valid instruction
in_ready  out  1  ID instruction accepted this cycle
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data, id_imm  in  XLEN  regfile reads, sign-extended immediate
id_rs1, id_rs2, id_rd  in  5  register indices
id_alu_src  in  1  1: operand B = immediate
id_alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved
id_funct3  in  3  instruction funct3
id_funct7_5  in  1  instruction bit 30
id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  control
exmem_rd, memwb_rd  in  5  forwarding destinations
exmem_reg_write, memwb_reg_write  in  1  forwarding enables
exmem_result, memwb_result  in  XLEN  forwarding values
alu_a, alu_b  out  XLEN  ALU operands
alu_ctrl  out  4  ALU control
ex_store_data  out  XLEN  forwarded rs2 value
ex_pc  out  XLEN  registered PC
ex_rd  out  5  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  out  1 each  registered control

Behaviour:
- Reset (rst=1 at a clk edge): every registered field is 0, except ex_pc = RESET_PC. Forwarding never matches x0, so alu_a = alu_b = 0 and alu_ctrl = 0000 after reset.
- load_use (combinational) = ex_valid & ex_mem_read & (ex_rd != 0) & in_valid & (id_rs1 == ex_rd | id_rs2 == ex_rd).
- in_ready = ~stall & ~load_use. During flush, in_ready is 1 and the ID instruction is consumed and discarded.
- Edge priority is rst > flush > stall > load_use > normal.
  - flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch and ex_illegal all cleared; data fields are don't-care.
  - stall: all registers hold. A simultaneous flush still wins.
  - load_use: bubble inserted (same clearing as flush); the ID instruction stays pending. The next cycle load_use is 0, because the EX slot is no longer a valid load, so the instruction enters with MEM/WB forwarding.
  - normal: if in_valid, all id_* fields are captured and ex_valid <= 1. Otherwise a bubble is inserted.
- ALU control is decoded at capture and registered; its latency is one cycle from ID, identical to the data.
  - alu_op 00 -> 0010; alu_op 01 -> 0110.
  - alu_op 10, funct3 000 -> 0110 if (funct7_5 & ~id_alu_src), else 0010.
  - alu_op 10, funct3 111 -> 0000; funct3 110 -> 0001.
  - Any other funct3, or alu_op 11 -> 1111 with ex_illegal <= 1, ex_reg_write <= 0, ex_mem_write <= 0.
- Forwarding is combinational from the registered rs1/rs2 indices:
  - Source is EX/MEM if exmem_reg_write & exmem_rd != 0 & exmem_rd == rs.
  - Otherwise MEM/WB under the same conditions.
  - Otherwise the registered regfile data. EX/MEM has priority when both match.
- Operand outputs: alu_a = fwd_rs1; alu_b = ex_alu_src ? ex_imm : fwd_rs2; ex_store_data = fwd_rs2 regardless of alu_src.
- Forwarded values track the forwarding inputs every cycle, including while stalled. Registered data itself is not refreshed during a stall.
- Arithmetic: none. All widths are XLEN with no extension here; the immediate arrives already sign-extended.

Test Plan:
- Reset then idle: rst held 2 cycles, in_valid=0 -> ex_valid=0, alu_ctrl=0000, alu_a=alu_b=0, ex_pc=RESET_PC, in_ready=1.
- Decode sweep: alu_op=10, alu_src=0 with (funct3, funct7_5) = (000,1), (000,0), (111,x), (110,x), (001,0) -> alu_ctrl 0110, 0010, 0000, 0001, 1111; the last also gives ex_illegal=1 and ex_reg_write=0. addi with funct7_5=1 and alu_src=1 -> 0010.
- Forward priority: EX holds rs1=5. With exmem_rd=5/result=0x11 and memwb_rd=5/result=0x22, both enabled -> alu_a=0x11. Then exmem_reg_write=0 -> alu_a=0x22. With rs1=0 and exmem_rd=0 -> alu_a = registered data.
- Load-use: lw x3 in EX (ex_mem_read=1, ex_rd=3), ID add x4,x3,x1 in_valid=1 -> in_ready=0. Next edge: ex_valid=0. Following edge: add captured, and memwb_rd=3, result=0xABCD forwards to alu_a=0xABCD.
- Stall/flush: stall=1 for 3 cycles with in_valid=1 -> EX outputs frozen, in_ready=0. stall=1 and flush=1 together -> ex_valid=0 next edge. flush alone with in_valid=1 -> in_ready=1, ex_valid=0.
- Reset mid-operation: valid store in EX with stall=1, then rst=1 -> ex_valid=0, ex_mem_write=0 next edge.
